// File: rtl/mmio_port_responder_if.sv
// Processor-side MMIO bus bundle for mmio_port_responder.
// The processor drives the master modport; the responder uses the slave modport.
interface mmio_port_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, Ready
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, Ready
  );
endinterface

// File: rtl/mmio_port_responder.sv
// Four-register MMIO port block with a fixed one-cycle ack, a synchronized input port and a change detector.
// Optional macro MMIO_PORT_IRQ_EN adds a registered Irq output and a writable MASK bit 8 as its enable.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  mmio_port_responder_if.slave       bus,
  input  logic [7:0]                 PortIn,
  output logic [31:0]                PortOut
`ifdef MMIO_PORT_IRQ_EN
  ,
  output logic                       Irq
`endif
);

`ifdef MMIO_PORT_IRQ_EN
  localparam int unsigned MASK_W = 9;
`else
  localparam int unsigned MASK_W = 8;
`endif

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2 or 3");
  end

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t             r_state;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic [31:0]        r_port_out;
  logic [MASK_W-1:0]  r_mask;
  logic               r_chg;
  logic [7:0]         r_sync [SYNC_STAGES];
  logic [7:0]         r_prev;
`ifdef MMIO_PORT_IRQ_EN
  logic               r_irq;
`endif

  logic        w_hit;
  logic        w_req;
  logic        w_wr;
  logic        w_start;
  logic        w_chg_set;
  logic        w_chg_clr;
  logic [7:0]  w_sync_last;
  logic [31:0] w_rd_val;

  assign w_sync_last = r_sync[SYNC_STAGES-1];
  assign w_hit       = (bus.Address[31:4] == BASE_ADDR[31:4]) && (bus.Address[1:0] == 2'b00);
  assign w_req       = bus.MemRead | bus.MemWrite;
  assign w_wr        = bus.MemWrite;
  assign w_start     = (r_state == S_IDLE) && w_hit && w_req;
  assign w_chg_set   = |((w_sync_last ^ r_prev) & r_mask[7:0]);
  // Only a pure read clears CHG; a combined read/write is a write.
  assign w_chg_clr   = w_start && !w_wr && (bus.Address[3:2] == 2'd2);

  always_comb begin
    w_rd_val = '0;
    unique case (bus.Address[3:2])
      2'd0: w_rd_val = r_port_out;
      2'd1: w_rd_val = {24'h0, w_sync_last};
      2'd2: w_rd_val = {31'h0, r_chg};
      2'd3: w_rd_val = 32'(r_mask);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_port_out <= '0;
      r_mask     <= '0;
      r_chg      <= 1'b0;
      r_prev     <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
`ifdef MMIO_PORT_IRQ_EN
      r_irq      <= 1'b0;
`endif
    end else begin
      r_sync[0] <= PortIn;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync_last;

      if (w_chg_set)      r_chg <= 1'b1;
      else if (w_chg_clr) r_chg <= 1'b0;

`ifdef MMIO_PORT_IRQ_EN
      r_irq <= r_chg & r_mask[8];
`endif

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_ACK;
            r_ready <= 1'b1;
            r_rdata <= w_wr ? '0 : w_rd_val;
            if (w_wr) begin
              if (bus.Address[3:2] == 2'd0) r_port_out <= bus.WriteData;
              if (bus.Address[3:2] == 2'd3) r_mask     <= bus.WriteData[MASK_W-1:0];
            end
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_rdata <= '0;
        end
      endcase
    end
  end

  assign bus.Ready    = r_ready;
  assign bus.ReadData = r_rdata;
  assign PortOut      = r_port_out;
`ifdef MMIO_PORT_IRQ_EN
  assign Irq          = r_irq;
`endif

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed testbench for mmio_port_responder; expected values are hand-computed constants.
// Covers the Irq path when compiled with MMIO_PORT_IRQ_EN.
module tb_mmio_port_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int unsigned SYNC = 2;

  logic        clk;
  logic        reset;
  logic [7:0]  port_in;
  logic [31:0] port_out;
`ifdef MMIO_PORT_IRQ_EN
  logic        irq;
  localparam logic [31:0] MASK_ALL = 32'h0000_01FF;
`else
  localparam logic [31:0] MASK_ALL = 32'h0000_00FF;
`endif

  int tests;
  int fails;

  mmio_port_responder_if bus ();

  mmio_port_responder #(
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .PortIn  (port_in),
    .PortOut (port_out)
`ifdef MMIO_PORT_IRQ_EN
    ,
    .Irq     (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request, wait up to 10 cycles for Ready; lat=0 means no Ready seen.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdat, output int lat, output logic [31:0] po_at_ready);
    bus.MemRead = rd; bus.MemWrite = wr; bus.Address = a; bus.WriteData = d;
    lat = 0; rdat = '0; po_at_ready = port_out;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.Ready === 1'b1) begin
        lat = i; rdat = bus.ReadData; po_at_ready = port_out;
        break;
      end
    end
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    cycles(1);
  endtask

  logic [31:0] rd;
  logic [31:0] po;
  int          lat;

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; port_in = 8'h00;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Address = '0; bus.WriteData = '0;
    cycles(3);
    check("rst_ready", 32'(bus.Ready), 32'd0);
    check("rst_rdata", bus.ReadData, 32'd0);
    check("rst_portout", port_out, 32'd0);
    reset = 1'b1;
    cycles(2);

    access(1, 0, BASE + 32'h0, 32'h0, rd, lat, po);
    check("rd0_latency", 32'(lat), 32'd1);
    check("rd0_data", rd, 32'd0);
    check("rdata_idle", bus.ReadData, 32'd0);

    access(0, 1, BASE + 32'h0, 32'hDEAD_BEEF, rd, lat, po);
    check("wr0_latency", 32'(lat), 32'd1);
    check("wr0_portout_at_ready", po, 32'hDEAD_BEEF);
    check("wr0_rdata", rd, 32'd0);
    access(1, 0, BASE + 32'h0, 32'h0, rd, lat, po);
    check("rd0_back", rd, 32'hDEAD_BEEF);

    port_in = 8'hA5;
    cycles(SYNC + 1);
    access(1, 0, BASE + 32'h4, 32'h0, rd, lat, po);
    check("portin_a5", rd, 32'h0000_00A5);

    access(0, 1, BASE + 32'hC, 32'hFFFF_FFFF, rd, lat, po);
    access(1, 0, BASE + 32'hC, 32'h0, rd, lat, po);
    check("mask_all", rd, MASK_ALL);
    access(0, 1, BASE + 32'hC, 32'h0000_0001, rd, lat, po);
    access(1, 0, BASE + 32'h8, 32'h0, rd, lat, po);
    check("status_initial", rd, 32'd0);

    port_in = 8'hA4;
    cycles(SYNC + 3);
    access(1, 0, BASE + 32'h8, 32'h0, rd, lat, po);
    check("status_set", rd, 32'd1);
    access(1, 0, BASE + 32'h8, 32'h0, rd, lat, po);
    check("status_cleared", rd, 32'd0);

    port_in = 8'hA6;
    cycles(SYNC + 3);
    access(1, 0, BASE + 32'h8, 32'h0, rd, lat, po);
    check("status_unmasked", rd, 32'd0);

    access(0, 1, BASE + 32'h2, 32'h1234_5678, rd, lat, po);
    check("miss_unaligned_ready", 32'(lat), 32'd0);
    check("miss_unaligned_portout", port_out, 32'hDEAD_BEEF);
    access(0, 1, BASE + 32'h10, 32'h1234_5678, rd, lat, po);
    check("miss_outside_ready", 32'(lat), 32'd0);
    check("miss_outside_portout", port_out, 32'hDEAD_BEEF);

    access(1, 1, BASE + 32'h0, 32'h0000_55AA, rd, lat, po);
    check("rdwr_latency", 32'(lat), 32'd1);
    check("rdwr_rdata", rd, 32'd0);
    check("rdwr_portout", po, 32'h0000_55AA);

    access(0, 1, BASE + 32'h4, 32'hFFFF_FFFF, rd, lat, po);
    check("wr_ro_latency", 32'(lat), 32'd1);
    access(1, 0, BASE + 32'h4, 32'h0, rd, lat, po);
    check("wr_ro_noeffect", rd, 32'h0000_00A6);

    // Held read: ACK, IDLE, ACK, IDLE
    bus.MemRead = 1'b1; bus.Address = BASE + 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ready_%0d", i), 32'(bus.Ready), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.MemRead = 1'b0;
    cycles(2);

    bus.MemWrite = 1'b1; bus.Address = BASE + 32'hC; bus.WriteData = 32'h3;
    @(posedge clk); #1;
    check("rst_ack_ready_before", 32'(bus.Ready), 32'd1);
    reset = 1'b0; bus.MemWrite = 1'b0;
    @(posedge clk); #1;
    check("rst_ack_ready_after", 32'(bus.Ready), 32'd0);
    check("rst_ack_portout", port_out, 32'd0);
    reset = 1'b1;
    cycles(SYNC + 3);
    access(1, 0, BASE + 32'hC, 32'h0, rd, lat, po);
    check("rst_ack_mask", rd, 32'd0);

`ifdef MMIO_PORT_IRQ_EN
    access(0, 1, BASE + 32'hC, 32'h0000_0101, rd, lat, po);
    access(1, 0, BASE + 32'h8, 32'h0, rd, lat, po);
    check("irq_idle", 32'(irq), 32'd0);
    port_in = 8'hA7;
    cycles(SYNC + 4);
    check("irq_set", 32'(irq), 32'd1);
    cycles(3);
    check("irq_held", 32'(irq), 32'd1);
    access(1, 0, BASE + 32'h8, 32'h0, rd, lat, po);
    check("irq_status", rd, 32'd1);
    cycles(1);
    check("irq_cleared", 32'(irq), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
